// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the alarm-clock mode controller: field limits,
// counter widths, mode and field encodings, the decoded button action and
// small helpers used by the controller.
// -----------------------------------------------------------------------------
package clock_pkg;

    localparam int MAX_HOUR = 23;
    localparam int MAX_MIN  = 59;
    localparam int MAX_SEC  = 59;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    // Encoding 2'b11 is deliberately left out; the controller recovers from it.
    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'b00,
        MODE_ADJ_TIME  = 2'b01,
        MODE_ADJ_ALARM = 2'b10
    } mode_t;

    typedef enum logic {
        FIELD_HOURS   = 1'b0,
        FIELD_MINUTES = 1'b1
    } field_t;

    // The one button action taken in a cycle after priority resolution.
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_CENTRE,
        ACT_UP,
        ACT_DOWN,
        ACT_LEFT,
        ACT_RIGHT
    } action_t;

    // Priority: centre > up > down > left > right; the rest are dropped.
    function automatic action_t decode_buttons(input logic c, input logic u,
                                               input logic d, input logic l,
                                               input logic r);
        if (c)      return ACT_CENTRE;
        else if (u) return ACT_UP;
        else if (d) return ACT_DOWN;
        else if (l) return ACT_LEFT;
        else if (r) return ACT_RIGHT;
        else        return ACT_NONE;
    endfunction

    // Value a wrapping counter takes after one increment.
    function automatic logic [5:0] inc_wrap(input logic [5:0] v,
                                            input logic [5:0] limit);
        return (v == limit) ? 6'd0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Modulo-(MAX+1) up/down counter used for every time and alarm field.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (value -> 0)
//   inc       - count up, MAX wraps to 0
//   dec       - count down, 0 wraps to MAX
//   clr       - force to 0 (highest priority)
//   value     - registered count
//   wrap      - high in the cycle an increment rolls MAX over to 0 (carry out)
// Priority when several controls are high: clr > inc > dec.
// -----------------------------------------------------------------------------
module mod_counter #(
    parameter int MAX = 59,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign wrap = inc && !clr && (value == MAX_V);

    // NOTE: registers are written with non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= (value == MAX_V) ? '0 : value + 1'b1;
        end else if (dec) begin
            value <= (value == '0) ? MAX_V : value - 1'b1;
        end
    end

endmodule

// File: rtl/clock_mode_controller.sv
// -----------------------------------------------------------------------------
// clock_mode_controller
// Alarm clock core: time of day, alarm setting, three-mode user interface
// driven by five button pulses, and the alarm ringer.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   tick_1hz        - one-cycle pulse per second
//   btn_c/u/d/l/r   - one-cycle button pulses (centre, up, down, left, right)
//   hours/minutes/seconds      - current time
//   alarm_hours/alarm_minutes  - alarm setting
//   mode            - 00 CLOCK, 01 ADJ_TIME, 10 ADJ_ALARM
//   field_sel       - field under adjustment (0 hours, 1 minutes)
//   alarm_en        - alarm armed
//   alarm_ring      - alarm sounding
// All outputs are registered; an input in cycle N shows up in cycle N+1.
// -----------------------------------------------------------------------------
module clock_mode_controller
    import clock_pkg::*;
#(
    parameter int ALARM_SECS = 60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic              btn_c,
    input  logic              btn_u,
    input  logic              btn_d,
    input  logic              btn_l,
    input  logic              btn_r,
    output logic [HOUR_W-1:0] hours,
    output logic [MIN_W-1:0]  minutes,
    output logic [SEC_W-1:0]  seconds,
    output logic [HOUR_W-1:0] alarm_hours,
    output logic [MIN_W-1:0]  alarm_minutes,
    output logic [1:0]        mode,
    output logic              field_sel,
    output logic              alarm_en,
    output logic              alarm_ring
);

    mode_t      mode_q;
    field_t     field_q;
    logic       alarm_en_q;
    logic       alarm_ring_q;
    logic [7:0] ring_cnt;

    assign mode       = mode_q;
    assign field_sel  = field_q;
    assign alarm_en   = alarm_en_q;
    assign alarm_ring = alarm_ring_q;

    // ------------------------------------------------------------------
    // Button resolution. While ringing, any button only silences, so the
    // effective action is suppressed.
    // ------------------------------------------------------------------
    logic    any_btn;
    action_t act;

    assign any_btn = btn_c | btn_u | btn_d | btn_l | btn_r;
    assign act     = (alarm_ring_q && any_btn)
                     ? ACT_NONE
                     : decode_buttons(btn_c, btn_u, btn_d, btn_l, btn_r);

    // ------------------------------------------------------------------
    // Counter controls
    // ------------------------------------------------------------------
    logic sec_inc, sec_clr, sec_wrap;
    logic min_inc, min_dec, min_wrap;
    logic hour_inc, hour_dec, hour_wrap;
    logic amin_inc, amin_dec, amin_wrap;
    logic ahour_inc, ahour_dec, ahour_wrap;
    logic tick_adv;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        tick_adv  = 1'b0;
        sec_inc   = 1'b0;
        sec_clr   = 1'b0;
        min_inc   = 1'b0;
        min_dec   = 1'b0;
        hour_inc  = 1'b0;
        hour_dec  = 1'b0;
        amin_inc  = 1'b0;
        amin_dec  = 1'b0;
        ahour_inc = 1'b0;
        ahour_dec = 1'b0;

        // Time runs in CLOCK and ADJ_ALARM, and is frozen in ADJ_TIME.
        tick_adv = tick_1hz &&
                   (mode_q == MODE_CLOCK || mode_q == MODE_ADJ_ALARM);

        sec_inc  = tick_adv;
        min_inc  = tick_adv && sec_wrap;
        hour_inc = tick_adv && sec_wrap && min_wrap;

        if (mode_q == MODE_ADJ_TIME && (act == ACT_UP || act == ACT_DOWN)) begin
            // Adjusting either field restarts the minute; no inter-field carry
            // because hour_inc above only follows ticks, never adjustment.
            sec_clr = 1'b1;
            if (field_q == FIELD_HOURS) begin
                hour_inc = (act == ACT_UP);
                hour_dec = (act == ACT_DOWN);
            end else begin
                min_inc  = (act == ACT_UP);
                min_dec  = (act == ACT_DOWN);
            end
        end

        if (mode_q == MODE_ADJ_ALARM) begin
            if (field_q == FIELD_HOURS) begin
                ahour_inc = (act == ACT_UP);
                ahour_dec = (act == ACT_DOWN);
            end else begin
                amin_inc  = (act == ACT_UP);
                amin_dec  = (act == ACT_DOWN);
            end
        end
    end

    mod_counter #(.MAX(MAX_SEC), .W(SEC_W)) u_seconds (
        .clk(clk), .rst(rst), .inc(sec_inc), .dec(1'b0), .clr(sec_clr),
        .value(seconds), .wrap(sec_wrap)
    );

    mod_counter #(.MAX(MAX_MIN), .W(MIN_W)) u_minutes (
        .clk(clk), .rst(rst), .inc(min_inc), .dec(min_dec), .clr(1'b0),
        .value(minutes), .wrap(min_wrap)
    );

    mod_counter #(.MAX(MAX_HOUR), .W(HOUR_W)) u_hours (
        .clk(clk), .rst(rst), .inc(hour_inc), .dec(hour_dec), .clr(1'b0),
        .value(hours), .wrap(hour_wrap)
    );

    mod_counter #(.MAX(MAX_MIN), .W(MIN_W)) u_alarm_minutes (
        .clk(clk), .rst(rst), .inc(amin_inc), .dec(amin_dec), .clr(1'b0),
        .value(alarm_minutes), .wrap(amin_wrap)
    );

    mod_counter #(.MAX(MAX_HOUR), .W(HOUR_W)) u_alarm_hours (
        .clk(clk), .rst(rst), .inc(ahour_inc), .dec(ahour_dec), .clr(1'b0),
        .value(alarm_hours), .wrap(ahour_wrap)
    );

    // Day rollover and alarm-field wraps have no consumer here.
    logic unused_wraps;
    assign unused_wraps = hour_wrap ^ amin_wrap ^ ahour_wrap;

    // ------------------------------------------------------------------
    // Alarm trigger: this tick lands exactly on alarm_hours:alarm_minutes:00.
    // Only the :59 -> :00 tick can match, so the alarm fires once per minute
    // at most and cannot retrigger after being silenced.
    // ------------------------------------------------------------------
    logic [5:0] next_min;
    logic [5:0] next_hour;
    logic       trig;

    assign next_min  = inc_wrap(minutes, 6'(MAX_MIN));
    assign next_hour = (minutes == MIN_W'(MAX_MIN))
                       ? inc_wrap({1'b0, hours}, 6'(MAX_HOUR))
                       : {1'b0, hours};

    assign trig = (mode_q == MODE_CLOCK) && alarm_en_q && tick_1hz &&
                  (seconds == SEC_W'(MAX_SEC)) &&
                  (next_min == alarm_minutes) &&
                  (next_hour == {1'b0, alarm_hours});

    // ------------------------------------------------------------------
    // Mode FSM with field select and alarm enable
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= MODE_CLOCK;
            field_q    <= FIELD_HOURS;
            alarm_en_q <= 1'b0;
        end else begin
            case (mode_q)
                MODE_CLOCK: begin
                    if (act == ACT_CENTRE) begin
                        mode_q  <= MODE_ADJ_TIME;
                        field_q <= FIELD_HOURS;
                    end else if (act == ACT_UP) begin
                        alarm_en_q <= ~alarm_en_q;
                    end
                end
                MODE_ADJ_TIME: begin
                    if (act == ACT_CENTRE) begin
                        mode_q  <= MODE_ADJ_ALARM;
                        field_q <= FIELD_HOURS;
                    end else if (act == ACT_LEFT) begin
                        field_q <= FIELD_HOURS;
                    end else if (act == ACT_RIGHT) begin
                        field_q <= FIELD_MINUTES;
                    end
                end
                MODE_ADJ_ALARM: begin
                    if (act == ACT_CENTRE) begin
                        mode_q  <= MODE_CLOCK;
                        field_q <= FIELD_HOURS;
                    end else if (act == ACT_LEFT) begin
                        field_q <= FIELD_HOURS;
                    end else if (act == ACT_RIGHT) begin
                        field_q <= FIELD_MINUTES;
                    end
                end
                default: begin
                    // Unused encoding: recover to CLOCK.
                    mode_q  <= MODE_CLOCK;
                    field_q <= FIELD_HOURS;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Ringer: counts ticks since the trigger; any button silences it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_ring_q <= 1'b0;
            ring_cnt     <= '0;
        end else if (alarm_ring_q) begin
            if (any_btn) begin
                alarm_ring_q <= 1'b0;
                ring_cnt     <= '0;
            end else if (tick_1hz) begin
                if (ring_cnt == 8'(ALARM_SECS - 1)) begin
                    alarm_ring_q <= 1'b0;
                    ring_cnt     <= '0;
                end else begin
                    ring_cnt <= ring_cnt + 8'd1;
                end
            end
        end else if (trig) begin
            alarm_ring_q <= 1'b1;
            ring_cnt     <= '0;
        end
    end

endmodule

// File: tb/tb_clock_mode_controller.sv
// -----------------------------------------------------------------------------
// tb_clock_mode_controller
// Scoreboard bench: the driver applies one cycle of stimulus, steps a
// behavioural model (time kept as seconds-of-day) and queues the expected
// outputs; a monitor pops and compares one entry after every clock edge.
// -----------------------------------------------------------------------------
module tb_clock_mode_controller;

    localparam int ALARM_SECS = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btn_c = 1'b0, btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
    logic [4:0] hours, alarm_hours;
    logic [5:0] minutes, seconds, alarm_minutes;
    logic [1:0] mode;
    logic       field_sel, alarm_en, alarm_ring;

    always #5 clk = ~clk;

    clock_mode_controller #(.ALARM_SECS(ALARM_SECS)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
        .btn_c(btn_c), .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
        .mode(mode), .field_sel(field_sel),
        .alarm_en(alarm_en), .alarm_ring(alarm_ring)
    );

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [4:0] ah;
        logic [5:0] am;
        logic [1:0] mode;
        logic       field;
        logic       en;
        logic       ring;
    } snap_t;

    snap_t exp_q[$];
    snap_t mon_exp;
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_t;      // seconds since midnight
    int m_ah, m_am, m_mode, m_field, m_rcnt;
    bit m_en, m_ring;

    task automatic model_reset();
        m_t = 0; m_ah = 0; m_am = 0; m_mode = 0; m_field = 0;
        m_en = 0; m_ring = 0; m_rcnt = 0;
    endtask

    function automatic snap_t model_snap();
        snap_t e;
        e.h = 5'(m_t / 3600);
        e.m = 6'((m_t / 60) % 60);
        e.s = 6'(m_t % 60);
        e.ah = 5'(m_ah);
        e.am = 6'(m_am);
        e.mode = 2'(m_mode);
        e.field = m_field[0];
        e.en = m_en;
        e.ring = m_ring;
        return e;
    endfunction

    function automatic snap_t dut_snap();
        return {hours, minutes, seconds, alarm_hours, alarm_minutes,
                mode, field_sel, alarm_en, alarm_ring};
    endfunction

    task automatic model_step(input bit tk, input bit c, input bit u,
                              input bit d, input bit l, input bit r);
        bit any_b, tick_adv, trig;
        int act, h, mi;
        any_b    = c | u | d | l | r;
        tick_adv = tk && (m_mode == 0 || m_mode == 2);
        trig     = (m_mode == 0) && m_en && tk &&
                   (((m_t + 1) % 86400) == m_ah * 3600 + m_am * 60);
        h  = m_t / 3600;
        mi = (m_t / 60) % 60;
        if (m_ring && any_b) act = 0;
        else if (c) act = 1;
        else if (u) act = 2;
        else if (d) act = 3;
        else if (l) act = 4;
        else if (r) act = 5;
        else act = 0;

        if (m_ring) begin
            if (any_b) begin
                m_ring = 0; m_rcnt = 0;
            end else if (tk) begin
                m_rcnt++;
                if (m_rcnt == ALARM_SECS) begin
                    m_ring = 0; m_rcnt = 0;
                end
            end
        end else if (trig) begin
            m_ring = 1; m_rcnt = 0;
        end

        case (m_mode)
            0: begin
                if (act == 1) begin m_mode = 1; m_field = 0; end
                else if (act == 2) m_en = !m_en;
            end
            1: begin
                if (act == 1) begin m_mode = 2; m_field = 0; end
                else if (act == 4) m_field = 0;
                else if (act == 5) m_field = 1;
                else if (act == 2 || act == 3) begin
                    if (m_field == 0) h  = (act == 2) ? (h + 1) % 24 : (h + 23) % 24;
                    else              mi = (act == 2) ? (mi + 1) % 60 : (mi + 59) % 60;
                    m_t = h * 3600 + mi * 60;
                end
            end
            default: begin
                if (act == 1) begin m_mode = 0; m_field = 0; end
                else if (act == 4) m_field = 0;
                else if (act == 5) m_field = 1;
                else if (act == 2 || act == 3) begin
                    if (m_field == 0) m_ah = (act == 2) ? (m_ah + 1) % 24 : (m_ah + 23) % 24;
                    else              m_am = (act == 2) ? (m_am + 1) % 60 : (m_am + 59) % 60;
                end
            end
        endcase

        if (tick_adv) m_t = (m_t + 1) % 86400;
    endtask

    // ---------------- driver ----------------
    // One cycle of stimulus; returns after the edge with outputs settled.
    task automatic step(input bit tk, input bit c, input bit u,
                        input bit d, input bit l, input bit r);
        @(negedge clk);
        tick_1hz = tk; btn_c = c; btn_u = u; btn_d = d; btn_l = l; btn_r = r;
        model_step(tk, c, u, d, l, r);
        exp_q.push_back(model_snap());
        @(posedge clk);
        #2;
        tick_1hz = 0; btn_c = 0; btn_u = 0; btn_d = 0; btn_l = 0; btn_r = 0;
    endtask

    task automatic press(input bit c, input bit u, input bit d,
                         input bit l, input bit r);
        step(0, c, u, d, l, r);
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1;
        tick_1hz = 1; btn_u = 1; btn_c = 1;   // must be ignored under reset
        #1;
        check({tag, "_hours"},   hours, 0);
        check({tag, "_minutes"}, minutes, 0);
        check({tag, "_seconds"}, seconds, 0);
        check({tag, "_ahours"},  alarm_hours, 0);
        check({tag, "_amin"},    alarm_minutes, 0);
        check({tag, "_mode"},    mode, 0);
        check({tag, "_field"},   field_sel, 0);
        check({tag, "_en"},      alarm_en, 0);
        check({tag, "_ring"},    alarm_ring, 0);
        model_reset();
        repeat (2) @(negedge clk);
        tick_1hz = 0; btn_u = 0; btn_c = 0;
        rst = 0;
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check("outputs{h,m,s,ah,am,mode,field,en,ring}", dut_snap(), mon_exp);
        end
    end

    // ---------------- sequence ----------------
    initial begin
        int budget;
        do_reset("reset");
        step(0, 0, 0, 0, 0, 0);
        check("post_reset_time", {hours, minutes, seconds}, 0);

        // centre and up together in CLOCK: centre wins
        press(1, 1, 0, 0, 0);
        check("cu_mode", mode, 1);
        check("cu_alarm_en", alarm_en, 0);

        // ADJ_TIME hours 0 down -> 23, seconds 0, frozen under ticks
        press(0, 0, 1, 0, 0);
        check("adj_hour_wrap", hours, 23);
        check("adj_sec_clr", seconds, 0);
        ticks(5);
        check("adj_frozen", {hours, minutes, seconds}, {5'd23, 6'd0, 6'd0});

        // minutes 0 down -> 59, back to CLOCK, roll over midnight
        press(0, 0, 0, 0, 1);
        press(0, 0, 1, 0, 0);
        check("adj_min_wrap", minutes, 59);
        press(1, 0, 0, 0, 0);
        press(1, 0, 0, 0, 0);
        check("back_to_clock", mode, 0);
        ticks(59);
        check("at_235959", {hours, minutes, seconds}, {5'd23, 6'd59, 6'd59});
        ticks(1);
        check("midnight", {hours, minutes, seconds}, 0);

        // alarm 07:30
        press(1, 0, 0, 0, 0);
        press(1, 0, 0, 0, 0);
        repeat (7) press(0, 1, 0, 0, 0);
        press(0, 0, 0, 0, 1);
        repeat (30) press(0, 0, 1, 0, 0);
        check("alarm_set", {alarm_hours, alarm_minutes}, {5'd7, 6'd30});
        press(1, 0, 0, 0, 0);
        press(0, 1, 0, 0, 0);
        check("alarm_armed", alarm_en, 1);

        // time 07:29:00 then run to the trigger
        press(1, 0, 0, 0, 0);
        repeat (7) press(0, 1, 0, 0, 0);
        press(0, 0, 0, 0, 1);
        repeat (29) press(0, 1, 0, 0, 0);
        press(1, 0, 0, 0, 0);
        press(1, 0, 0, 0, 0);
        ticks(59);
        check("pre_trigger_ring", alarm_ring, 0);
        ticks(1);
        check("trigger_ring", alarm_ring, 1);
        check("trigger_time", {hours, minutes, seconds}, {5'd7, 6'd30, 6'd0});
        ticks(ALARM_SECS - 1);
        check("ring_hold", alarm_ring, 1);
        ticks(1);
        check("ring_timeout", alarm_ring, 0);

        // ring again and silence with centre
        press(1, 0, 0, 0, 0);
        press(0, 0, 0, 0, 1);
        press(0, 0, 1, 0, 0);
        press(0, 0, 1, 0, 0);
        press(1, 0, 0, 0, 0);
        press(1, 0, 0, 0, 0);
        ticks(60);
        check("retrigger_ring", alarm_ring, 1);
        press(1, 0, 0, 0, 0);
        check("silence_ring", alarm_ring, 0);
        check("silence_mode", mode, 0);
        check("silence_en", alarm_en, 1);

        // 12:34:56 in ADJ_ALARM, then reset mid-operation
        press(1, 0, 0, 0, 0);
        repeat (5) press(0, 1, 0, 0, 0);
        press(0, 0, 0, 0, 1);
        repeat (4) press(0, 1, 0, 0, 0);
        press(1, 0, 0, 0, 0);
        ticks(56);
        check("pre_reset_time", {hours, minutes, seconds}, {5'd12, 6'd34, 6'd56});
        check("pre_reset_mode", mode, 2);
        do_reset("midrst");

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 2) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 11) == 0);
        end

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
